mem_bus_arbiter: RTL and testbench

//  Shares the single memory port between the multi-cycle CPU (fixed priority) and a burst DMA engine.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/mem_bus_arbiter_dma_beat_ctr.sv | 50 +++++
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the CPU/DMA memory bus arbiter.
// Write-type codes, DMA FSM states and the default beat stride.
package mem_bus_pkg;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_WORD = 2'd1;
  localparam logic [1:0] MW_DMA  = 2'd2;
  localparam logic [1:0] MW_BYTE = 2'd3;

  localparam int unsigned ADDR_STEP_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/mem_bus_arbiter_dma_beat_ctr.sv
// DMA beat counter: current beat address and beats still to issue.
// Ports: clk/rst, load (base,len), step; outputs cur, last, empty.
module dma_beat_ctr
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  input  logic             step,
  output logic [31:0]      cur,
  output logic             last,
  output logic             empty
);

  logic [31:0]      cur_q, cur_d;
  logic [LEN_W-1:0] rem_q, rem_d;

  always_comb begin
    cur_d = cur_q;
    rem_d = rem_q;
    if (load) begin
      cur_d = base;
      rem_d = len;
    end else if (step) begin
      // 32-bit add wraps silently past 0xFFFF_FFFF
      cur_d = cur_q + 32'(ADDR_STEP);
      rem_d = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      rem_q <= '0;
    end else begin
      cur_q <= cur_d;
      rem_q <= rem_d;
    end
  end

  assign cur   = cur_q;
  assign last  = (rem_q == LEN_W'(1));
  assign empty = (rem_q == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter: CPU has absolute priority, DMA fills idle cycles.
// Ports: cpu_* pass-through, dma_* control/stream, mem_* to memory.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_rd,
  input  logic [1:0]       cpu_wr,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  input  logic             dma_start,
  input  logic             dma_dir,
  input  logic [31:0]      dma_base,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_busy,
  output logic             dma_done,
  output logic [31:0]      dma_rdata,
  output logic             dma_rvalid,
  input  logic             dma_rready,
  input  logic [31:0]      dma_wdata,
  input  logic             dma_wvalid,
  output logic             dma_wready,
  output logic             mem_rd,
  output logic [1:0]       mem_wr,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  dma_state_e  state_q, state_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        cpu_act;
  logic        rd_beat, wr_beat;
  logic        ctr_load;
  logic [31:0] ctr_cur;
  logic        ctr_last, ctr_empty;

  assign cpu_act = cpu_rd | (cpu_wr != MW_NONE);

  // A read beat also needs room in the one-entry output holding slot
  assign rd_beat = (state_q == ST_RD) & ~ctr_empty & ~cpu_act
                 & (~rvalid_q | dma_rready);
  assign wr_beat = (state_q == ST_WR) & ~cpu_act & dma_wvalid;

  assign ctr_load = (state_q == ST_IDLE) & dma_start
                  & (dma_len != '0);

  dma_beat_ctr #(
    .ADDR_STEP (ADDR_STEP),
    .LEN_W     (LEN_W)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .base  (dma_base),
    .len   (dma_len),
    .step  (rd_beat | wr_beat),
    .cur   (ctr_cur),
    .last  (ctr_last),
    .empty (ctr_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dma_start) begin
          if (dma_len == '0) state_d = ST_DONE;
          else if (dma_dir)  state_d = ST_WR;
          else               state_d = ST_RD;
        end
      end
      // Finish only once the last held beat has been taken
      ST_RD: begin
        if (ctr_empty & rvalid_q & dma_rready)
          state_d = ST_DONE;
      end
      ST_WR: begin
        if (wr_beat & ctr_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_beat) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_rdata;
    end else if (rvalid_q & dma_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = MW_NONE;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_act: begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      rd_beat: begin
        mem_rd   = 1'b1;
        mem_addr = ctr_cur;
      end
      wr_beat: begin
        mem_wr    = MW_DMA;
        mem_addr  = ctr_cur;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rdata  = mem_rdata;
  assign dma_busy   = (state_q == ST_RD) | (state_q == ST_WR);
  assign dma_done   = (state_q == ST_DONE);
  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;
  assign dma_wready = wr_beat;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter.
// Queue-based transfer model checked every negedge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_rd = 1'b0;
  logic [1:0]  cpu_wr = 2'd0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        dma_start = 1'b0;
  logic        dma_dir = 1'b0;
  logic [31:0] dma_base = '0;
  logic [15:0] dma_len = '0;
  logic        dma_busy, dma_done;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        dma_rready = 1'b0;
  logic [31:0] dma_wdata = '0;
  logic        dma_wvalid = 1'b0;
  logic        dma_wready;
  logic        mem_rd;
  logic [1:0]  mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign mem_rdata = memf(mem_addr);

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .dma_start(dma_start), .dma_dir(dma_dir),
    .dma_base(dma_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .dma_rready(dma_rready), .dma_wdata(dma_wdata),
    .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: a transfer is a queue of addresses still to go,
  // plus one held read word waiting for the sink.
  bit          m_active, m_dir, m_done, m_held;
  logic [31:0] m_data;
  logic [31:0] m_q[$];

  bit          e_cpu, e_rd, e_wr;
  logic [31:0] e_addr;
  bit          o_active, o_held, o_empty, o_done;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(dma_busy), 0);
      chk("rst_done", 32'(dma_done), 0);
      chk("rst_rvalid", 32'(dma_rvalid), 0);
      chk("rst_rdata", dma_rdata, 0);
      chk("rst_wready", 32'(dma_wready), 0);
      chk("rst_mem_rd", 32'(mem_rd), 0);
      chk("rst_mem_wr", 32'(mem_wr), 0);
      chk("rst_mem_addr", mem_addr, 0);
      m_active = 0; m_done = 0; m_held = 0;
      m_data = '0; m_q.delete();
    end else begin
      e_cpu = cpu_rd || (cpu_wr != 2'd0);
      e_rd = m_active && !m_dir && m_q.size() > 0 && !e_cpu
          && (!m_held || dma_rready);
      e_wr = m_active && m_dir && m_q.size() > 0 && !e_cpu
          && dma_wvalid;
      e_addr = e_cpu ? cpu_addr :
               (e_rd || e_wr) ? m_q[0] : 32'd0;
      chk("busy", 32'(dma_busy), 32'(m_active));
      chk("done", 32'(dma_done), 32'(m_done));
      chk("rvalid", 32'(dma_rvalid), 32'(m_held));
      chk("rdata", dma_rdata, m_data);
      chk("wready", 32'(dma_wready), 32'(e_wr));
      chk("mem_rd", 32'(mem_rd),
          e_cpu ? 32'(cpu_rd) : 32'(e_rd));
      chk("mem_wr", 32'(mem_wr),
          e_cpu ? 32'(cpu_wr) : (e_wr ? 32'd2 : 32'd0));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata,
          e_cpu ? cpu_wdata : (e_wr ? dma_wdata : 32'd0));
      chk("cpu_rdata", cpu_rdata, memf(e_addr));

      o_active = m_active; o_held = m_held;
      o_empty = (m_q.size() == 0); o_done = m_done;
      m_done = 0;
      if (!o_active && !o_done && dma_start) begin
        if (dma_len == 0) m_done = 1;
        else begin
          m_active = 1;
          m_dir = dma_dir;
          for (int i = 0; i < int'(dma_len); i++)
            m_q.push_back(dma_base + 32'(2 * i));
        end
      end
      if (e_rd) begin
        m_held = 1;
        m_data = memf(m_q.pop_front());
      end else if (o_held && dma_rready) begin
        m_held = 0;
      end
      if (o_active && !m_dir && o_empty && o_held && dma_rready) begin
        m_active = 0; m_done = 1;
      end
      if (e_wr) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_active = 0; m_done = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_start = 0; dma_wvalid = 0;
  endtask

  task automatic start(input bit dir, input logic [31:0] b,
                       input logic [15:0] l);
    dma_start = 1; dma_dir = dir; dma_base = b; dma_len = l;
  endtask

  task automatic wait_done(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      cyc();
      dma_start = 0;
      #1;
      if (dma_done) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
  endtask

  task automatic rd_basic();
    cyc(); idle_in(); dma_rready = 1;
    start(0, 32'h100, 16'd4);
    for (int k = 0; k < 4; k++) begin
      cyc(); dma_start = 0; #1;
      chk("t2_addr", mem_addr, 32'h100 + 32'(2 * k));
      chk("t2_rd", 32'(mem_rd), 1);
    end
    wait_done(10);
  endtask

  initial begin
    cyc(); cyc();
    rst = 0;
    // 1: CPU pass-through
    cyc(); cpu_rd = 1; cpu_addr = 32'h10; #1;
    chk("t1_rd", 32'(mem_rd), 1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_rdata", cpu_rdata, memf(32'h10));
    cyc(); cpu_rd = 0; cpu_wr = 1; cpu_addr = 32'h20;
    cpu_wdata = 32'hDEAD_BEEF; #1;
    chk("t1_wr", 32'(mem_wr), 1);
    chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    // 2: plain read burst
    rd_basic();
    // 3: read burst, CPU reads every other cycle
    cyc(); idle_in(); start(0, 32'h400, 16'd3);
    for (int k = 0; k < 12; k++) begin
      cyc(); dma_start = 0;
      cpu_rd = k[0]; cpu_addr = 32'h5000 + 32'(k);
    end
    cyc(); idle_in();
    // 4: write burst with gaps and CPU writes
    cyc(); start(1, 32'h200, 16'd2); dma_wvalid = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); dma_start = 0;
      dma_wvalid = (k % 3) != 0;
      dma_wdata = 32'hA000_0000 + 32'(k);
      cpu_wr = (k % 2 == 0) ? 2'd3 : 2'd0;
      cpu_addr = 32'h6000 + 32'(k);
    end
    cyc(); idle_in();
    // 5: zero length and start while busy
    cyc(); start(0, 32'h700, 16'd0);
    cyc(); dma_start = 0; #1;
    chk("t5_done", 32'(dma_done), 1);
    chk("t5_mem_rd", 32'(mem_rd), 0);
    cyc(); #1;
    chk("t5_done_off", 32'(dma_done), 0);
    dma_rready = 0; start(0, 32'h800, 16'd3);
    cyc(); start(1, 32'h900, 16'd2);
    cyc(); dma_start = 0;
    cyc(); cyc(); dma_rready = 1;
    wait_done(12);
    // 6: asynchronous reset mid-burst
    cyc(); start(0, 32'h300, 16'd5);
    cyc(); dma_start = 0;
    cyc(); cyc(); #2 rst = 1; #1;
    chk("t6_busy", 32'(dma_busy), 0);
    chk("t6_rvalid", 32'(dma_rvalid), 0);
    chk("t6_rdata", dma_rdata, 0);
    chk("t6_mem_rd", 32'(mem_rd), 0);
    chk("t6_mem_addr", mem_addr, 0);
    cyc(); cyc(); rst = 0;
    rd_basic();
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cyc();
      idle_in();
      if ($urandom_range(9) < 3) begin
        if ($urandom_range(1) == 1) cpu_rd = 1;
        else cpu_wr = ($urandom_range(1) == 1) ? 2'd1 : 2'd3;
        cpu_addr = $urandom;
        cpu_wdata = $urandom;
      end
      dma_rready = $urandom_range(9) < 7;
      dma_wvalid = $urandom_range(9) < 6;
      dma_wdata = $urandom;
      if ($urandom_range(9) == 0)
        start($urandom_range(1) == 1,
              ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom,
              16'($urandom_range(5)));
    end
    cyc(); idle_in(); dma_rready = 1;
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
